// File: rtl/pipeline_hazard_controller_if.sv
// Decode-side bundle of the hazard controller: instruction in decode, branch outcome
// from EX, and the stall/issue/flush/forwarding controls handed back to the pipeline.
interface pipeline_hazard_controller_if;
    logic        ins_valid;
    logic [31:0] ins;
    logic        br_resolved;
    logic        br_taken;
    logic        stall;
    logic        issue;
    logic        flush;
    logic        ex_valid;
    logic [1:0]  mux_sel_A;
    logic [1:0]  mux_sel_B;

    modport master (
        output ins_valid, ins, br_resolved, br_taken,
        input  stall, issue, flush, ex_valid, mux_sel_A, mux_sel_B
    );

    modport slave (
        input  ins_valid, ins, br_resolved, br_taken,
        output stall, issue, flush, ex_valid, mux_sel_A, mux_sel_B
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage sequencer for a 5-stage MIPS pipeline: tracks EX/MEM/WB destinations,
// picks EX operand forwarding, stalls on load-use and conditional jumps, squashes after jumps.
module pipeline_hazard_controller #(
    parameter int REG_W   = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_BRWAIT = 2'd1,
        S_JFLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             writes;
        logic             is_ld;
        logic [REG_W-1:0] dest;
    } slot_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    state_t     state_q;
    slot_t      ex_q, mem_q, wb_q;
    logic       flush_q;
    logic [1:0] sel_a_q, sel_b_q;

    // Instruction decode
    logic [5:0]       opcode;
    logic             is_jmp, is_cj, is_ld, is_st, is_imm, is_alu;
    logic             writes, reads_a, reads_b;
    logic [REG_W-1:0] dest, src_a, src_b;

    assign opcode = bus.ins[31:26];
    assign dest   = bus.ins[21 +: REG_W];
    assign src_a  = bus.ins[16 +: REG_W];
    assign src_b  = bus.ins[11 +: REG_W];

    assign is_jmp = (opcode == 6'b011000);
    assign is_cj  = (opcode[5:2] == 4'b0111);
    assign is_ld  = (opcode == 6'b010100);
    assign is_st  = (opcode == 6'b010101);
    assign is_imm = (opcode[5:3] == 3'b001);
    assign is_alu = ~(is_jmp | is_cj | is_ld | is_st | is_imm);

    assign writes  = is_alu | is_imm | is_ld;
    assign reads_a = ~is_jmp;
    assign reads_b = is_alu | is_cj | is_st;

    function automatic logic depends(input slot_t s, input logic rd, input logic [REG_W-1:0] src);
        return s.valid && s.writes && rd && (s.dest == src) && (!R0_ZERO || (src != '0));
    endfunction

    logic hit_ex_a, hit_mem_a, hit_wb_a;
    logic hit_ex_b, hit_mem_b, hit_wb_b;
    logic load_use;

    assign hit_ex_a  = depends(ex_q,  reads_a, src_a);
    assign hit_mem_a = depends(mem_q, reads_a, src_a);
    assign hit_wb_a  = depends(wb_q,  reads_a, src_a);
    assign hit_ex_b  = depends(ex_q,  reads_b, src_b);
    assign hit_mem_b = depends(mem_q, reads_b, src_b);
    assign hit_wb_b  = depends(wb_q,  reads_b, src_b);

    // A load still in EX has no data yet; the consumer must wait one cycle for MEM.
    assign load_use = ex_q.is_ld & (hit_ex_a | hit_ex_b);

    // Most recent producer wins; a WB hit reads the write-first register file.
    logic [1:0] sel_a_d, sel_b_d;
    always_comb begin
        sel_a_d = SEL_RF;
        if (hit_ex_a)       sel_a_d = SEL_EX;
        else if (hit_mem_a) sel_a_d = SEL_MEM;
        else if (hit_wb_a)  sel_a_d = SEL_RF;

        sel_b_d = SEL_RF;
        if (is_imm)         sel_b_d = SEL_IMM;
        else if (hit_ex_b)  sel_b_d = SEL_EX;
        else if (hit_mem_b) sel_b_d = SEL_MEM;
        else if (hit_wb_b)  sel_b_d = SEL_RF;
    end

    logic issue_c, stall_c;
    always_comb begin
        issue_c = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            S_RUN: begin
                issue_c = bus.ins_valid & ~load_use;
                stall_c = bus.ins_valid &  load_use;
            end
            S_BRWAIT: stall_c = 1'b1;
            default: ;
        endcase
    end

    slot_t dec_slot;
    always_comb begin
        dec_slot        = '0;
        dec_slot.valid  = 1'b1;
        dec_slot.writes = writes;
        dec_slot.is_ld  = is_ld;
        dec_slot.dest   = dest;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            flush_q <= 1'b0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            flush_q <= 1'b0;
            if (issue_c) begin
                ex_q    <= dec_slot;
                sel_a_q <= sel_a_d;
                sel_b_q <= sel_b_d;
            end else begin
                ex_q    <= '0;
                sel_a_q <= SEL_RF;
                sel_b_q <= SEL_RF;
            end

            case (state_q)
                S_RUN: begin
                    if (issue_c && is_jmp) begin
                        state_q <= S_JFLUSH;
                        flush_q <= 1'b1;
                    end else if (issue_c && is_cj) begin
                        state_q <= S_BRWAIT;
                    end
                end
                S_BRWAIT: begin
                    if (bus.br_resolved) begin
                        if (bus.br_taken) begin
                            state_q <= S_JFLUSH;
                            flush_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign bus.stall     = stall_c;
    assign bus.issue     = issue_c;
    assign bus.flush     = flush_q;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.mux_sel_A = sel_a_q;
    assign bus.mux_sel_B = sel_b_q;

    // Immediate/funct bits and the WB load flag carry no hazard information.
    logic unused_bits;
    assign unused_bits = ^{bus.ins[10:0], wb_q.is_ld};

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Decode-stage sequencer for the 5-stage MIPS pipeline.
- Tracks the destination registers of the three in-flight instructions (EX, MEM, WB) and generates the EX operand-mux selects (forwarding).
- Stalls decode for load-use hazards and conditional jumps, and squashes the fetched instruction behind taken jumps.
- Sits between the IF/ID register and the EX-stage operand muxes, next to the dependency check block.

Parameters:
- REG_W, 5, register-address width.
- R0_ZERO, 1, when 1 register 0 never creates a dependency.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- ins_valid  input  1  IF/ID holds a valid instruction.
- ins  input  32  instruction in decode: [31:26] opcode, [25:21] dest, [20:16] srcA, [15:11] srcB.
- br_resolved  input  1  EX reports the conditional-jump outcome this cycle.
- br_taken  input  1  outcome; qualified by br_resolved.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- issue  output  1  combinational; decode instruction enters EX at the next edge.
- flush  output  1  registered; invalidate IF/ID at the next edge.
- ex_valid  output  1  registered; EX holds a real instruction, not a bubble.
- mux_sel_A  output  2  registered; EX operand-A source.
- mux_sel_B  output  2  registered; EX operand-B source.

Behaviour:
- Decode classes:
  - JMP = 011000.
  - CJ = 0111xx.
  - LD = 010100.
  - ST = 010101.
  - IMM = 001xxx.
  - ALU = all other opcodes.
- Register writes: ALU, IMM and LD write dest. ST, JMP and CJ write nothing.
- Register reads:
  - ALU, CJ, ST read srcA and srcB.
  - IMM and LD read srcA only.
  - JMP reads nothing.
- Slots EX, MEM, WB each hold {valid, writes, is_ld, dest}. Every edge: WB<=MEM, MEM<=EX, EX<=decode if issue, else a bubble (valid=0).
- A dependency exists when a slot is valid, writes, dest equals the read source, and the source is not r0 (when R0_ZERO=1).
- Load-use hazard: the EX slot is LD and the decode instruction depends on it.
- FSM states:
  - RUN:
    - issue = ins_valid & ~load-use hazard.
    - stall = ins_valid & load-use hazard; a bubble enters EX.
    - Issue of JMP -> JFLUSH. Issue of CJ -> BRWAIT.
  - BRWAIT:
    - stall=1, issue=0, bubbles enter EX.
    - On br_resolved: taken -> JFLUSH, not taken -> RUN.
    - Stays in BRWAIT indefinitely until br_resolved.
  - JFLUSH:
    - Lasts exactly one cycle; flush=1, issue=0, stall=0, then -> RUN.
    - The instruction then in IF/ID is discarded, ignoring ins_valid.
- flush=1 exactly while in JFLUSH; 0 in all other states.
- Forwarding selects are computed at the issue edge from pre-shift slots and held with the instruction in EX:
  - 01: the EX slot matches (EX/MEM ALU result).
  - 10: else the MEM slot matches (MEM/WB result, including load data).
  - 00: else register file; WB-slot matches read the register file, which is write-first.
  - Most recent match wins.
- mux_sel_B = 11 for IMM (immediate), regardless of srcB.
- The 11 encoding is never driven on mux_sel_A.
- On a non-issue edge: mux_sel_A/B <= 00 and ex_valid <= 0.
- Load-use timing: a stall of exactly one cycle. The consumer then issues with the LD in MEM, so mux_sel = 10.
- One source matching multiple slots resolves by priority. A and B are resolved independently; both may match the same slot.
- Reset (asynchronous, any time, including mid-BRWAIT or JFLUSH):
  - FSM -> RUN, all slots invalid.
  - ex_valid=0, flush=0, mux_sel_A=mux_sel_B=00.
  - Comb outputs follow from reset state: stall=0, issue=ins_valid.

Test Plan:
- ADD r3,r1,r2 then ADD r4,r3,r3, back-to-back -> second issues with no stall; mux_sel_A=01, mux_sel_B=01.
- LD r5 then ADD r6,r5,r0 -> stall=1 for exactly one cycle, EX bubble (ex_valid=0), then issue with mux_sel_A=10, mux_sel_B=00.
- ADD r7,… ; NOP ; NOP ; ADD r8,r7,r7 -> mux_sel 00, since the WB match reads the register file. With a single NOP instead -> 10.
- JMP followed by a valid ins -> flush=1 for one cycle after the JMP issues; following ins not issued; RUN afterwards.
- CJ, br_resolved held low for 3 cycles then br_resolved=1, br_taken=1 -> stall=1 for 4 cycles, then flush=1 for one cycle. Repeat with br_taken=0 -> no flush, issue resumes the next cycle.
- Assert reset low during BRWAIT -> immediately stall=0, flush=0, ex_valid=0, mux_sel=00. After release, IMM r9,r9 with r9 written 1 cycle earlier -> mux_sel_A=01, mux_sel_B=11.
